// File: rtl/ram_fifo_obuf.sv
// Two-entry output buffer that sits after the RAM read port of ram_fifo_ctrl.
// A capture and a pop may happen in the same cycle; flush empties it synchronously.
module ram_fifo_obuf #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_wr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_pop,
    output logic [1:0]            o_count,
    output logic [DATA_WIDTH-1:0] o_head
);

    logic [DATA_WIDTH-1:0] r_mem [0:1];
    logic                  r_head;
    logic [1:0]            r_count;
    logic                  w_wr_idx;

    // Tail slot is head when empty, the other slot when one entry is held.
    assign w_wr_idx = r_head ^ r_count[0];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_head  <= 1'b0;
            r_count <= 2'd0;
        end else if (i_flush) begin
            r_head  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (i_pop) begin
                r_head <= ~r_head;
            end
            r_count <= r_count + {1'b0, i_wr} - {1'b0, i_pop};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_wr && !i_flush) begin
            r_mem[w_wr_idx] <= i_wdata;
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_head];

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Streaming valid/ready FIFO sequencer around an external simple dual-port RAM
// with 1-cycle registered read; a 2-entry output buffer hides the read latency.
module ram_fifo_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH+1:0] level,
    output logic [ADDR_WIDTH-1:0] ram_wraddress,
    output logic                  ram_wren,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic [ADDR_WIDTH-1:0] ram_rdaddress,
    output logic                  ram_rden,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_ram_count;
    logic                  r_rd_pending;

    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_issue;
    logic [1:0]            w_obuf_count;
    logic [DATA_WIDTH-1:0] w_obuf_head;

    assign w_full    = (r_ram_count == DEPTH);
    assign in_ready  = ~reset & ~flush & ~w_full;
    assign w_push    = in_valid & in_ready;
    assign out_valid = (w_obuf_count != 2'd0) & ~flush;
    assign w_pop     = out_valid & out_ready;

    // Issue only if the word will have an obuf slot when it lands next cycle;
    // ram_count excludes this cycle's write, so no read-during-write on one address.
    assign w_issue = (r_ram_count != '0) & ~flush &
                     (({1'b0, w_obuf_count} + {2'b00, r_rd_pending}) < (3'd2 + {2'b00, w_pop}));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_ram_count  <= '0;
            r_rd_pending <= 1'b0;
        end else if (flush) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_ram_count  <= '0;
            r_rd_pending <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end
            r_ram_count  <= r_ram_count + {{ADDR_WIDTH{1'b0}}, w_push}
                                        - {{ADDR_WIDTH{1'b0}}, w_issue};
            r_rd_pending <= w_issue;
        end
    end

    ram_fifo_obuf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_obuf (
        .i_clk   (clock),
        .i_rst   (reset),
        .i_flush (flush),
        .i_wr    (r_rd_pending),
        .i_wdata (ram_q),
        .i_pop   (w_pop),
        .o_count (w_obuf_count),
        .o_head  (w_obuf_head)
    );

    assign out_data      = w_obuf_head;
    assign ram_wren      = w_push;
    assign ram_wraddress = r_wr_ptr;
    assign ram_data      = in_data;
    assign ram_rden      = w_issue;
    assign ram_rdaddress = r_rd_ptr;

    assign level = {1'b0, r_ram_count} + (ADDR_WIDTH+2)'(r_rd_pending)
                 + (ADDR_WIDTH+2)'(w_obuf_count);

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with a behavioural 1-cycle-latency RAM; a word-queue
// model tracks FIFO contents and a negedge monitor checks every handshake.
module tb_ram_fifo_ctrl;

    localparam int DW  = 32;
    localparam int AW  = 2;
    localparam int CAP = (1 << AW) + 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [AW+1:0] level;
    logic [AW-1:0] ram_wraddress;
    logic          ram_wren;
    logic [DW-1:0] ram_data;
    logic [AW-1:0] ram_rdaddress;
    logic          ram_rden;
    logic [DW-1:0] ram_q;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    ram_fifo_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .level         (level),
        .ram_wraddress (ram_wraddress),
        .ram_wren      (ram_wren),
        .ram_data      (ram_data),
        .ram_rdaddress (ram_rdaddress),
        .ram_rden      (ram_rden),
        .ram_q         (ram_q)
    );

    // Behavioural simple dual-port RAM, registered read.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clock) begin
        if (ram_wren) mem[ram_wraddress] <= ram_data;
        if (ram_rden) ram_q <= mem[ram_rdaddress];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            check("level", {28'd0, level}, exp_q.size());
            if (exp_q.size() == 0) begin
                check("empty_out_valid", {31'd0, out_valid}, 32'd0);
                check("empty_rden", {31'd0, ram_rden}, 32'd0);
            end
            if (!flush && exp_q.size() < 4) check("in_ready_space", {31'd0, in_ready}, 32'd1);
            if (exp_q.size() == CAP) check("in_ready_full", {31'd0, in_ready}, 32'd0);
            if (ram_wren && ram_rden) begin
                n_tests++;
                if (ram_wraddress == ram_rdaddress) begin
                    n_fail++;
                    $display("FAIL rw_hazard: rdaddress %0d equals wraddress %0d", ram_rdaddress, ram_wraddress);
                end
            end
            if (flush) begin
                check("flush_out_valid", {31'd0, out_valid}, 32'd0);
                check("flush_in_ready", {31'd0, in_ready}, 32'd0);
                exp_q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL pop_underflow: got 0x%0h expected no word", out_data);
                    end else begin
                        check("out_data", out_data, exp_q.pop_front());
                    end
                end
                if (in_valid && in_ready) exp_q.push_back(in_data);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_latency(input logic [DW-1:0] d);
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = 1'b1;
        @(negedge clock);
        check("lat_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clock);
        #1 in_valid = 1'b0;
        @(negedge clock);
        check("lat_ov_t1", {31'd0, out_valid}, 32'd0);
        check("lat_level_t1", {28'd0, level}, 32'd1);
        @(negedge clock);
        check("lat_ov_t2", {31'd0, out_valid}, 32'd0);
        @(negedge clock);
        check("lat_ov_t3", {31'd0, out_valid}, 32'd1);
        check("lat_data_t3", out_data, d);
        step();
    endtask

    task automatic drain(input int budget);
        int k;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while (level != 0 && k < budget) begin
            step();
            k++;
        end
        check("drain_done", {28'd0, level}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int acc;
        logic [DW-1:0] d;

        // Reset state
        #2;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_level", {28'd0, level}, 32'd0);
        check("rst_wren", {31'd0, ram_wren}, 32'd0);
        check("rst_rden", {31'd0, ram_rden}, 32'd0);
        check("rst_wraddr", {30'd0, ram_wraddress}, 32'd0);
        check("rst_rdaddr", {30'd0, ram_rdaddress}, 32'd0);
        step();
        step();
        reset = 1'b0;
        step();

        // Single word latency
        push_latency(32'hA1);
        step();

        // Fill to capacity with consumer stalled
        out_ready = 1'b0;
        d = 32'h10;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_data  = d;
            @(negedge clock);
            if (in_ready) begin
                acc++;
                d++;
            end
            step();
        end
        in_valid = 1'b0;
        check("fill_accepted", acc, CAP);
        @(negedge clock);
        check("fill_level", {28'd0, level}, CAP);
        check("fill_no_rden", {31'd0, ram_rden}, 32'd0);
        check("fill_in_ready", {31'd0, in_ready}, 32'd0);

        // Drain from full: no bubbles, space reopens after first issue
        step();
        out_ready = 1'b1;
        for (int i = 0; i < CAP; i++) begin
            @(negedge clock);
            check("drain_ov", {31'd0, out_valid}, 32'd1);
            check("drain_data", out_data, 32'h10 + i);
            if (i == 0) check("drain_in_ready0", {31'd0, in_ready}, 32'd0);
            if (i == 1) check("drain_in_ready1", {31'd0, in_ready}, 32'd1);
        end
        step();
        @(negedge clock);
        check("drain_empty", {31'd0, out_valid}, 32'd0);
        step();

        // Streaming 20 words with wrap: 1 word/cycle after 3-cycle fill
        out_ready = 1'b1;
        for (int c = 0; c < 23; c++) begin
            in_valid = (c < 20);
            in_data  = c;
            @(negedge clock);
            if (c < 20) check("stream_in_ready", {31'd0, in_ready}, 32'd1);
            check("stream_ov", {31'd0, out_valid}, (c >= 3) ? 32'd1 : 32'd0);
            step();
        end
        in_valid = 1'b0;
        drain(10);

        // Flush while a read is pending
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_data  = 32'h31 + c;
            step();
        end
        flush     = 1'b1;
        in_data   = 32'h99;
        out_ready = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        check("post_flush_level", {28'd0, level}, 32'd0);
        check("post_flush_ov", {31'd0, out_valid}, 32'd0);
        step();
        push_latency(32'h55);
        step();

        // Asynchronous reset mid-stream
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            step();
        end
        @(posedge clock);
        #3 reset = 1'b1;
        #1;
        check("areset_ov", {31'd0, out_valid}, 32'd0);
        check("areset_in_ready", {31'd0, in_ready}, 32'd0);
        check("areset_wren", {31'd0, ram_wren}, 32'd0);
        check("areset_rden", {31'd0, ram_rden}, 32'd0);
        check("areset_level", {28'd0, level}, 32'd0);
        step();
        step();
        in_valid = 1'b0;
        #2 reset = 1'b0;
        @(negedge clock);
        check("post_reset_level", {28'd0, level}, 32'd0);
        step();
        push_latency(32'h77);

        // Randomised traffic with occasional flush, varying pressure per block
        for (int blk = 0; blk < 4; blk++) begin
            int pv, pr;
            pv = $urandom_range(30, 90);
            pr = (blk == 1) ? 10 : $urandom_range(20, 90);
            for (int c = 0; c < 100; c++) begin
                in_valid  = ($urandom_range(0, 99) < pv);
                in_data   = $urandom;
                out_ready = ($urandom_range(0, 99) < pr);
                flush     = ($urandom_range(0, 99) < 2);
                step();
            end
        end
        drain(20);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
